isp_path_ctrl: RTL and testbench

ISP_PATH_CTRL -- requirements
Module: isp_path_ctrl

---
 rtl/isp_pkg.sv | 45 ++++
 rtl/isp_cbar_gen.sv | 28 ++
 rtl/isp_path_ctrl.sv | 168 ++++++++++++++++
 tb/tb_isp_path_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isp_pkg
// Description : Shared path-mode encodings, FSM state codes and colour-bar palette.
// Revision    : 1.0 - initial release
// ============================================================================
package isp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_PROC = 2'd1,
        MODE_CBAR = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    localparam logic [15:0] c_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] c_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] c_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] c_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] c_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] c_BAR_RED     = 16'hF800;
    localparam logic [15:0] c_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] c_BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] v;
        case (idx)
            3'd0:    v = c_BAR_WHITE;
            3'd1:    v = c_BAR_YELLOW;
            3'd2:    v = c_BAR_CYAN;
            3'd3:    v = c_BAR_GREEN;
            3'd4:    v = c_BAR_MAGENTA;
            3'd5:    v = c_BAR_RED;
            3'd6:    v = c_BAR_BLUE;
            default: v = c_BAR_BLACK;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isp_cbar_gen.sv
`default_nettype none
// ============================================================================
// Module      : isp_cbar_gen
// Description : Maps a pixel column to one of eight equal-width RGB565 bars.
// Revision    : 1.0 - initial release
// ============================================================================
module isp_cbar_gen
    import isp_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int PIX_W = 10
) (
    input  logic [PIX_W-1:0] pix_cnt,
    output logic [15:0]      colour
);

    localparam int c_BAR_LEN = (IMG_W >= 8) ? IMG_W / 8 : 1;

    logic [31:0] w_idx;

    // Widths that are not a multiple of eight leave a remainder; it stays on the last bar.
    always_comb begin
        w_idx  = 32'(pix_cnt) / 32'(c_BAR_LEN);
        colour = (w_idx > 32'd7) ? bar_colour(3'd7) : bar_colour(w_idx[2:0]);
    end

endmodule
`default_nettype wire

// File: rtl/isp_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : isp_path_ctrl
// Description : Per-frame path selector (pass / process / colour bar) with frame tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module isp_path_ctrl
    import isp_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        dataEn,
    input  logic [15:0] Din,
    input  logic [1:0]  mode_req,
    input  logic [15:0] proc_Din,
    input  logic        proc_En,
    output logic        stage_En,
    output logic [15:0] Dout,
    output logic        outEn,
    output logic [1:0]  mode_act,
    output logic        frame_done,
    output logic        err
);

    localparam int c_PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_OW = $clog2(IMG_W * IMG_H + 1);

    localparam logic [c_PW-1:0] c_PIX_LAST  = c_PW'(IMG_W - 1);
    localparam logic [c_LW-1:0] c_LINE_LAST = c_LW'(IMG_H - 1);
    localparam logic [c_OW-1:0] c_OUT_TOTAL = c_OW'(IMG_W * IMG_H);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_vsync_d;
    logic            w_vsync_rise;
    logic [c_PW-1:0] r_pix_cnt;
    logic [c_LW-1:0] r_line_cnt;
    logic [c_OW-1:0] r_out_cnt;
    mode_t           r_mode_act;
    logic [15:0]     r_dout;
    logic            r_out_en;
    logic            r_frame_done;
    logic            r_err;
    logic            w_accept;
    logic            w_stage_en;
    logic            w_proc_ok;
    logic            w_last_pix;
    logic            w_drain_done;
    logic [15:0]     w_bar_colour;

    // Reset loads 1 so a vsync already high at reset release is not seen as a rise.
    assign w_vsync_rise = vsync & ~r_vsync_d;
    assign w_last_pix   = (r_pix_cnt == c_PIX_LAST) && (r_line_cnt == c_LINE_LAST);
    assign w_drain_done = (r_out_cnt >= c_OUT_TOTAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_vsync_rise) w_next_state = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (w_vsync_rise)                w_next_state = c_ST_ACTIVE;
                else if (w_accept && w_last_pix) w_next_state = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_vsync_rise)      w_next_state = c_ST_ACTIVE;
                else if (w_drain_done) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = 1'b0;
        w_stage_en = 1'b0;
        w_proc_ok  = 1'b0;
        w_accept   = (r_state == c_ST_ACTIVE) && dataEn;
        w_stage_en = w_accept && (r_mode_act == MODE_PROC);
        w_proc_ok  = (r_state != c_ST_IDLE) && proc_En && (r_mode_act == MODE_PROC);
    end

    isp_cbar_gen #(
        .IMG_W (IMG_W),
        .PIX_W (c_PW)
    ) u_cbar (
        .pix_cnt (r_pix_cnt),
        .colour  (w_bar_colour)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d    <= 1'b1;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_out_cnt    <= '0;
            r_mode_act   <= MODE_PASS;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_frame_done <= (r_state == c_ST_DRAIN) && w_drain_done && !w_vsync_rise;
            if (w_vsync_rise) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_out_cnt  <= '0;
                r_mode_act <= mode_t'(mode_req);
                // A rise outside IDLE aborts the frame in flight.
                r_err      <= (r_state != c_ST_IDLE);
            end else begin
                if (dataEn && (r_state != c_ST_ACTIVE)) r_err <= 1'b1;
                if (w_accept) begin
                    if (r_pix_cnt == c_PIX_LAST) begin
                        r_pix_cnt  <= '0;
                        r_line_cnt <= (r_line_cnt == c_LINE_LAST) ? '0 : r_line_cnt + c_LW'(1);
                    end else begin
                        r_pix_cnt  <= r_pix_cnt + c_PW'(1);
                    end
                end
                if (r_out_en && (r_out_cnt < c_OUT_TOTAL)) r_out_cnt <= r_out_cnt + c_OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_en <= 1'b0;
            r_dout   <= '0;
        end else begin
            case (r_mode_act)
                MODE_PROC: begin
                    r_out_en <= w_proc_ok;
                    r_dout   <= w_proc_ok ? proc_Din : 16'h0000;
                end
                MODE_CBAR: begin
                    r_out_en <= w_accept;
                    r_dout   <= w_accept ? w_bar_colour : 16'h0000;
                end
                default: begin
                    r_out_en <= w_accept;
                    r_dout   <= w_accept ? Din : 16'h0000;
                end
            endcase
        end
    end

    assign stage_En   = w_stage_en;
    assign Dout       = r_dout;
    assign outEn      = r_out_en;
    assign mode_act   = r_mode_act;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_isp_path_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_isp_path_ctrl
// Description : Randomised bench for isp_path_ctrl against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isp_path_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int c_N   = IMG_W * IMG_H;
    localparam int c_PH_IDLE = 0;
    localparam int c_PH_RX   = 1;
    localparam int c_PH_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        dataEn = 1'b0;
    logic [15:0] Din = '0;
    logic [1:0]  mode_req = '0;
    logic [15:0] proc_Din = '0;
    logic        proc_En = 1'b0;
    logic        stage_En;
    logic [15:0] Dout;
    logic        outEn;
    logic [1:0]  mode_act;
    logic        frame_done;
    logic        err;

    isp_path_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .dataEn(dataEn), .Din(Din),
        .mode_req(mode_req), .proc_Din(proc_Din), .proc_En(proc_En),
        .stage_En(stage_En), .Dout(Dout), .outEn(outEn), .mode_act(mode_act),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int fd_seen = 0;

    logic [15:0] bar_ref [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Five-cycle processing stage emulation.
    logic        dly_en  [$];
    logic [15:0] dly_dat [$];

    int          m_phase;
    int          m_n;
    int          m_outs;
    logic [1:0]  m_mode;
    logic        m_err;
    logic        m_prev_vs;
    logic        m_oe;
    logic [15:0] m_dout;
    logic        m_fd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = c_PH_IDLE; m_n = 0; m_outs = 0; m_mode = 2'd0; m_err = 1'b0;
        m_prev_vs = 1'b1; m_oe = 1'b0; m_dout = '0; m_fd = 1'b0;
    endtask

    // Called just after a falling edge; drives one cycle and checks the result.
    task automatic step(input logic vs, input logic de, input logic [15:0] din, input logic [1:0] mreq);
        logic        pen, rise, acc, n_oe, n_fd;
        logic [15:0] pdin, n_d;
        int          m;
        pen  = dly_en.pop_front();
        pdin = dly_dat.pop_front();
        dly_en.push_back(de);
        dly_dat.push_back(din ^ 16'h5A5A);
        vsync = vs; dataEn = de; Din = din; mode_req = mreq; proc_En = pen; proc_Din = pdin;
        #1;
        rise = vs && !m_prev_vs;
        acc  = (m_phase == c_PH_RX) && de;
        check_val("stage_en", 32'(stage_En), 32'((m_mode == 2'd1) && acc));
        m = (m_mode == 2'd3) ? 0 : int'(m_mode);
        if (m == 1) begin
            n_oe = pen && (m_phase != c_PH_IDLE);
            n_d  = n_oe ? pdin : 16'h0;
        end else begin
            n_oe = acc;
            n_d  = !acc ? 16'h0 : (m == 2) ? bar_ref[(m_n % IMG_W) / (IMG_W / 8)] : din;
        end
        n_fd = (m_phase == c_PH_WAIT) && (m_outs >= c_N) && !rise;
        @(posedge clk);
        m_outs += int'(m_oe);
        if (rise) begin
            m_mode = mreq; m_n = 0; m_outs = 0;
            m_err = (m_phase != c_PH_IDLE);
            m_phase = c_PH_RX;
        end else begin
            if (de && m_phase != c_PH_RX) m_err = 1'b1;
            if (acc) begin
                m_n++;
                if (m_n == c_N) m_phase = c_PH_WAIT;
            end
            if (n_fd) m_phase = c_PH_IDLE;
        end
        m_prev_vs = vs; m_oe = n_oe; m_dout = n_d; m_fd = n_fd;
        @(negedge clk);
        check_val("out_en", 32'(outEn), 32'(m_oe));
        check_val("dout", 32'(Dout), 32'(m_dout));
        check_val("frame_done", 32'(frame_done), 32'(m_fd));
        check_val("err", 32'(err), 32'(m_err));
        check_val("mode_act", 32'(mode_act), 32'(m_mode));
        if (frame_done) fd_seen++;
    endtask

    task automatic run_frame(input logic [1:0] m, input int npix, input bit gaps,
                             input bit fix_din, input logic [15:0] din_fix,
                             input bit rnd_mreq, input int tail);
        int          sent;
        int          guard;
        logic        de;
        logic [15:0] d;
        logic [1:0]  mq;
        sent = 0; guard = 0;
        step(1'b1, 1'b0, 16'h0, m);
        step(1'b0, 1'b0, 16'h0, m);
        while (sent < npix && guard < 200) begin
            de = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            d  = fix_din ? din_fix : 16'($urandom);
            mq = rnd_mreq ? 2'($urandom) : m;
            step(1'b0, de, d, mq);
            if (de) sent++;
            guard++;
        end
        check_val("pix_budget", 32'(sent), 32'(npix));
        for (int i = 0; i < tail; i++) step(1'b0, 1'b0, 16'h0, rnd_mreq ? 2'($urandom) : m);
    endtask

    initial begin
        int fd0;
        for (int i = 0; i < 5; i++) begin
            dly_en.push_back(1'b0);
            dly_dat.push_back(16'h0);
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_outen", 32'(outEn), 32'd0);
        check_val("rst_dout", 32'(Dout), 32'd0);
        check_val("rst_mode", 32'(mode_act), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'h0, 2'd0);

        fd0 = fd_seen;
        run_frame(2'd0, 16, 1'b0, 1'b1, 16'h1234, 1'b0, 6);
        check_val("m0_fd_once", 32'(fd_seen - fd0), 32'd1);
        check_val("m0_err", 32'(err), 32'd0);

        fd0 = fd_seen;
        run_frame(2'd2, 16, 1'b0, 1'b0, 16'h0, 1'b0, 6);
        check_val("m2_fd_once", 32'(fd_seen - fd0), 32'd1);

        fd0 = fd_seen;
        run_frame(2'd1, 16, 1'b0, 1'b0, 16'h0, 1'b0, 10);
        check_val("m1_fd_once", 32'(fd_seen - fd0), 32'd1);

        fd0 = fd_seen;
        run_frame(2'd0, 10, 1'b0, 1'b0, 16'h0, 1'b0, 2);
        check_val("abort_no_fd", 32'(fd_seen - fd0), 32'd0);
        run_frame(2'd2, 16, 1'b0, 1'b0, 16'h0, 1'b0, 6);
        check_val("abort_err", 32'(err), 32'd1);
        check_val("abort_mode", 32'(mode_act), 32'd2);
        check_val("abort_fd_next", 32'(fd_seen - fd0), 32'd1);

        run_frame(2'd1, 16, 1'b1, 1'b0, 16'h0, 1'b1, 12);
        check_val("midchg_mode", 32'(mode_act), 32'd1);

        // Reset mid-frame with vsync held high across release.
        step(1'b1, 1'b0, 16'h0, 2'd2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom), 2'd3);
        #2;
        rst_n = 1'b0;
        vsync = 1'b1;
        #1;
        check_val("arst_stage", 32'(stage_En), 32'd0);
        check_val("arst_outen", 32'(outEn), 32'd0);
        check_val("arst_dout", 32'(Dout), 32'd0);
        check_val("arst_mode", 32'(mode_act), 32'd0);
        check_val("arst_fd", 32'(frame_done), 32'd0);
        check_val("arst_err", 32'(err), 32'd0);
        model_reset();
        dataEn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 2'd0);
        step(1'b0, 1'b0, 16'h0, 2'd0);
        fd0 = fd_seen;
        run_frame(2'd3, 16, 1'b0, 1'b0, 16'h0, 1'b0, 6);
        check_val("post_rst_fd", 32'(fd_seen - fd0), 32'd1);

        for (int f = 0; f < 10; f++) begin
            int npix;
            npix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame(2'($urandom), npix, 1'b1, 1'b0, 16'h0, 1'($urandom), (npix == 16) ? 12 : 2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
